// File: rtl/seg_scan8.sv
// rtl/seg_scan8.sv - eight-digit multiplexed 7-segment scan driver
// Pattern store, dwell/blank slot counters and registered segment/digit outputs.
module seg_scan8 #(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic [6:0] out,
  output logic [7:0] sel,
  output logic       frame_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYC);

  if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_params
    $error("seg_scan8: need SCAN_DIV >= 2 and 0 <= BLANK_CYC < SCAN_DIV");
  end

  logic [6:0]    r_mem [8];
  logic [CW-1:0] r_div_cnt;
  logic [2:0]    r_dig_idx;
  logic          w_blank;
  logic          w_slot_end;

  assign w_blank    = (r_div_cnt < BLANK_LEN);
  assign w_slot_end = (r_div_cnt == LAST_SLOT);

  // Outputs use the pre-edge counters and pattern, so a same-edge write shows one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      sel        <= 8'hFF;
      frame_tick <= 1'b0;
      r_div_cnt  <= '0;
      r_dig_idx  <= '0;
      for (int i = 0; i < 8; i++) r_mem[i] <= '0;
    end else begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
      if (!en) begin
        out        <= '0;
        sel        <= 8'hFF;
        frame_tick <= 1'b0;
        r_div_cnt  <= '0;
        r_dig_idx  <= '0;
      end else begin
        out        <= w_blank ? 7'h00 : r_mem[r_dig_idx];
        sel        <= w_blank ? 8'hFF : ~(8'h01 << r_dig_idx);
        frame_tick <= (r_dig_idx == 3'd7) && w_slot_end;
        if (w_slot_end) begin
          r_div_cnt <= '0;
          r_dig_idx <= r_dig_idx + 3'd1;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan8.sv
// tb/tb_seg_scan8.sv - bench for seg_scan8 (BLANK_CYC=1 and BLANK_CYC=0 instances)
// Reference model derives outputs from the enabled-edge count of the current scan run.
module tb_seg_scan8;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst, en, wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [6:0] out1, out0;
  logic [7:0] sel1, sel0;
  logic       tick1, tick0;

  int checks = 0;
  int errors = 0;

  seg_scan8 #(.SCAN_DIV(SD), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out1), .sel(sel1), .frame_tick(tick1)
  );

  seg_scan8 #(.SCAN_DIV(SD), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out(out0), .sel(sel0), .frame_tick(tick0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pattern array plus count of enabled edges since the scan last restarted.
  logic [6:0] m_mem [8];
  int         m_pos = 0;
  bit         m_valid = 1'b0;
  logic [6:0] e_out1, e_out0;
  logic [7:0] e_sel1, e_sel0;
  logic       e_tick;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 7'h00;
      m_pos = 0;
      e_out1 = 0; e_out0 = 0; e_sel1 = 8'hFF; e_sel0 = 8'hFF; e_tick = 0;
      m_valid = 1'b1;
    end else begin
      if (!en) begin
        m_pos = 0;
        e_out1 = 0; e_out0 = 0; e_sel1 = 8'hFF; e_sel0 = 8'hFF; e_tick = 0;
      end else begin
        int p, d, s;
        p = m_pos % (8 * SD);
        d = p / SD;
        s = p % SD;
        e_out0 = m_mem[d];
        e_sel0 = 8'hFF ^ (8'h01 << d);
        e_out1 = (s < 1) ? 7'h00 : m_mem[d];
        e_sel1 = (s < 1) ? 8'hFF : e_sel0;
        e_tick = (p == 8 * SD - 1);
        m_pos++;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("out_b1", out1, e_out1);
      chk("sel_b1", sel1, e_sel1);
      chk("tick_b1", tick1, e_tick);
      chk("out_b0", out0, e_out0);
      chk("sel_b0", sel0, e_sel0);
      chk("tick_b0", tick0, e_tick);
      chk("onehot_b1", int'($countones(~sel1) <= 1), 1);
      chk("onehot_b0", int'($countones(~sel0) <= 1), 1);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 7'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", out1, 0);
      chk("rst_sel", sel1, 8'hFF);
      chk("rst_tick", tick1, 0);
    end

    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("empty_out", out1, 0);
    end

    en = 1'b0;
    wr(3'd0, 7'h30);
    wr(3'd1, 7'h7B);
    wr(3'd2, 7'h11);
    en = 1'b1;

    for (int e = 1; e <= 100; e++) begin
      if (e == 11) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 7'h7E;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (e == 1) begin
        chk("E1_sel", sel1, 8'hFF); chk("E1_out", out1, 0);
        chk("E1_sel_nogap", sel0, 8'hFE); chk("E1_out_nogap", out0, 7'h30);
      end
      if (e >= 2 && e <= 4) begin
        chk("E2_4_sel", sel1, 8'hFE); chk("E2_4_out", out1, 7'h30);
      end
      if (e == 5) chk("E5_sel", sel1, 8'hFF);
      if (e >= 6 && e <= 8) begin
        chk("E6_8_sel", sel1, 8'hFD); chk("E6_8_out", out1, 7'h7B);
      end
      if (e == 11) begin
        chk("coll_old_out", out1, 7'h11); chk("coll_sel", sel1, 8'hFB);
      end
      if (e == 12) begin
        chk("coll_new_out", out1, 7'h7E); chk("coll_sel2", sel1, 8'hFB);
      end
      chk("tick_lit", tick1, int'(e % 32 == 0));
    end
    wr_en = 1'b0;

    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (22) @(negedge clk);
    chk("dig5_sel", sel1, 8'hDF);
    en = 1'b0;
    @(negedge clk);
    chk("drop_sel", sel1, 8'hFF); chk("drop_out", out1, 0);
    en = 1'b1;
    @(negedge clk);
    chk("re_E1_sel", sel1, 8'hFF);
    @(negedge clk);
    chk("re_E2_sel", sel1, 8'hFE); chk("re_E2_out", out1, 7'h30);

    repeat (24) @(negedge clk);
    chk("dig6_sel", sel1, 8'hBF);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_sel", sel1, 8'hFF); chk("mrst_out", out1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_E1_sel", sel1, 8'hFF); chk("mrst_E1_sel_nogap", sel0, 8'hFE);
    chk("mrst_E1_out_nogap", out0, 0);
    @(negedge clk);
    chk("mrst_E2_sel", sel1, 8'hFE); chk("mrst_E2_out", out1, 0);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (en) en = ($urandom_range(0, 149) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 7'($urandom_range(0, 127));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
